// File: rtl/arm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : arm_pkg                                                    |
// | Brief   : ARM condition codes, status-register bit indices, FSM type |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Status register layout {N,Z,C,V}
  localparam int N_ = 3;
  localparam int Z_ = 2;
  localparam int C_ = 1;
  localparam int V_ = 0;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    WAIT_FLAGS = 1'b1
  } exec_state_t;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/condition_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : Condition_Check                                            |
// | Brief   : Evaluates an ARM condition field against {N,Z,C,V}         |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module Condition_Check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] sr,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = sr[N_];
  assign w_z = sr[Z_];
  assign w_c = sr[C_];
  assign w_v = sr[V_];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !w_c || w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = w_z || (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule : Condition_Check
`default_nettype wire

// File: rtl/cond_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cond_exec_ctrl                                             |
// | Brief   : Execute-stage condition controller with flag-hazard stall  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module cond_exec_ctrl
  import arm_pkg::*;
#(
  parameter int MAX_PEND = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_cond,
  input  logic       in_s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_exec,
  output logic       out_set_flags,
  input  logic       flag_wb_valid,
  input  logic [3:0] flag_wb,
  output logic [3:0] sr,
  output logic [2:0] pend_cnt,
  output logic       wb_err
);

  localparam logic [2:0] C_MAX_PEND = 3'(MAX_PEND);

  logic        w_cond_pass;
  logic        w_hazard;
  logic        w_full;
  logic        w_accept;
  logic        w_inc;
  logic        w_dec;
  logic [2:0]  w_pend_next;
  exec_state_t r_state;

  Condition_Check u_condition_check (
    .cond (in_cond),
    .sr   (sr),
    .pass (w_cond_pass)
  );

  // Conditions only ever see committed flags, so any in-flight flag write blocks them.
  assign w_hazard = (pend_cnt != 3'd0) && (in_cond != COND_AL) && (in_cond != COND_NV);
  assign w_full   = (pend_cnt == C_MAX_PEND) && in_s;
  assign in_ready = (!out_valid || out_ready) && !w_hazard && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_inc    = w_accept && in_s && w_cond_pass;
  assign w_dec    = flag_wb_valid && (pend_cnt != 3'd0);

  always_comb begin
    w_pend_next = pend_cnt;
    case ({w_inc, w_dec})
      2'b10:   w_pend_next = pend_cnt + 3'd1;
      2'b01:   w_pend_next = pend_cnt - 3'd1;
      default: w_pend_next = pend_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_exec      <= 1'b0;
      out_set_flags <= 1'b0;
      sr            <= 4'b0000;
      pend_cnt      <= 3'd0;
      wb_err        <= 1'b0;
      r_state       <= RUN;
    end else begin
      if (w_accept) begin
        out_valid     <= 1'b1;
        out_exec      <= w_cond_pass;
        out_set_flags <= in_s && w_cond_pass;
      end else if (out_ready) begin
        out_valid     <= 1'b0;
      end

      // A stray writeback still commits its flags; it is only flagged as an error.
      if (flag_wb_valid) begin
        sr <= flag_wb;
        if (pend_cnt == 3'd0) begin
          wb_err <= 1'b1;
        end
      end

      pend_cnt <= w_pend_next;

      case (r_state)
        RUN: begin
          if (in_valid && w_hazard) begin
            r_state <= WAIT_FLAGS;
          end
        end
        WAIT_FLAGS: begin
          if (w_pend_next == 3'd0) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule : cond_exec_ctrl
`default_nettype wire

// File: tb/tb_cond_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cond_exec_ctrl                                          |
// | Brief   : Scoreboard bench for cond_exec_ctrl                        |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cond_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_cond = 4'd14;
  logic       in_s = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_exec;
  logic       out_set_flags;
  logic       flag_wb_valid = 1'b0;
  logic [3:0] flag_wb = 4'd0;
  logic [3:0] sr;
  logic [2:0] pend_cnt;
  logic       wb_err;

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per cycle on the falling edge
  logic [3:0] m_sr   = 4'd0;
  logic [2:0] m_pend = 3'd0;
  logic       m_err  = 1'b0;
  logic       m_ov   = 1'b0;
  logic [1:0] sb[$];
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  cond_exec_ctrl #(.MAX_PEND(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_cond       (in_cond),
    .in_s          (in_s),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_exec      (out_exec),
    .out_set_flags (out_set_flags),
    .flag_wb_valid (flag_wb_valid),
    .flag_wb       (flag_wb),
    .sr            (sr),
    .pend_cnt      (pend_cnt),
    .wb_err        (wb_err)
  );

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic       exp_ready, acc, pass, inc, dec;
    logic [1:0] front;
    exp_ready = (!m_ov || out_ready) && !((m_pend != 3'd0) && (in_cond < 4'd14))
                && !((m_pend == 3'd3) && in_s);
    if (mon_en) begin
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL mon_in_ready t=%0t: got %b expected %b", $time, in_ready, exp_ready);
      end
      checks++;
      if ({out_valid, sr, pend_cnt, wb_err} !== {m_ov, m_sr, m_pend, m_err}) begin
        errors++;
        $display("FAIL mon_state t=%0t: got ov=%b sr=%b pend=%0d err=%b expected ov=%b sr=%b pend=%0d err=%b",
                 $time, out_valid, sr, pend_cnt, wb_err, m_ov, m_sr, m_pend, m_err);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow t=%0t: got output with no expected entry", $time);
        end else begin
          front = sb.pop_front();
          if ({out_exec, out_set_flags} !== front) begin
            errors++;
            $display("FAIL sb_output t=%0t: got exec=%b set=%b expected exec=%b set=%b",
                     $time, out_exec, out_set_flags, front[1], front[0]);
          end
        end
      end
    end
    if (rst) begin
      m_sr = 4'd0; m_pend = 3'd0; m_err = 1'b0; m_ov = 1'b0;
      sb.delete();
    end else begin
      acc  = in_valid && exp_ready;
      pass = ref_cond(in_cond, m_sr);
      inc  = acc && in_s && pass;
      dec  = flag_wb_valid && (m_pend != 3'd0);
      if (flag_wb_valid) begin
        if (m_pend == 3'd0) m_err = 1'b1;
        m_sr = flag_wb;
      end
      m_pend = m_pend + {2'b00, inc} - {2'b00, dec};
      if (acc) begin
        sb.push_back({pass, in_s && pass});
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Commits flags v through a legitimate S-instruction + writeback pair
  task automatic set_sr(input logic [3:0] v);
    in_valid = 1'b1; in_cond = 4'd14; in_s = 1'b1;
    cyc();
    in_valid = 1'b0; in_s = 1'b0;
    flag_wb_valid = 1'b1; flag_wb = v;
    cyc();
    flag_wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++;
    if ({out_valid, out_exec, out_set_flags, sr, pend_cnt, wb_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_values: got ov=%b ex=%b sf=%b sr=%b pend=%0d err=%b expected all zero",
               out_valid, out_exec, out_set_flags, sr, pend_cnt, wb_err);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_cond_basic();
    in_valid = 1'b1; in_cond = 4'd0; in_s = 1'b0;
    cyc();
    checks++;
    if ({out_valid, out_exec} !== 2'b10) begin
      errors++;
      $display("FAIL eq_sr0: got ov=%b exec=%b expected ov=1 exec=0", out_valid, out_exec);
    end
    in_cond = 4'd1;
    cyc();
    checks++;
    if ({out_valid, out_exec} !== 2'b11) begin
      errors++;
      $display("FAIL ne_sr0: got ov=%b exec=%b expected ov=1 exec=1", out_valid, out_exec);
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0] flags [7] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1001, 4'b0110};
    for (int k = 0; k < 7; k++) begin
      set_sr(flags[k]);
      for (int c = 0; c < 16; c++) begin
        in_valid = 1'b1; in_cond = 4'(c); in_s = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready sr=%b cond=%0d: got %b expected 1", flags[k], c, in_ready);
        end
        cyc();
      end
      in_valid = 1'b0;
      cyc();
    end
  endtask

  task automatic test_hazard();
    in_valid = 1'b1; in_cond = 4'd14; in_s = 1'b1;
    cyc();
    in_cond = 4'd0; in_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hazard_stall cycle %0d: got in_ready=%b expected 0", i, in_ready);
      end
      cyc();
    end
    flag_wb_valid = 1'b1; flag_wb = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hazard_wb_cycle: got in_ready=%b expected 0", in_ready);
    end
    cyc();
    flag_wb_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, sr} !== 5'b1_0100) begin
      errors++;
      $display("FAIL hazard_release: got in_ready=%b sr=%b expected 1 0100", in_ready, sr);
    end
    cyc();
    checks++;
    if ({out_valid, out_exec} !== 2'b11) begin
      errors++;
      $display("FAIL eq_after_wb: got ov=%b exec=%b expected 1 1", out_valid, out_exec);
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_full();
    in_valid = 1'b1; in_cond = 4'd14; in_s = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({in_ready, pend_cnt} !== 4'b0_011) begin
        errors++;
        $display("FAIL full_stall %0d: got in_ready=%b pend=%0d expected 0 3", i, in_ready, pend_cnt);
      end
      if (i == 0) cyc();
    end
    flag_wb_valid = 1'b1; flag_wb = 4'b0000;
    cyc();
    #1;
    checks++;
    if ({in_ready, pend_cnt} !== 4'b1_010) begin
      errors++;
      $display("FAIL full_release: got in_ready=%b pend=%0d expected 1 2", in_ready, pend_cnt);
    end
    // Fourth accept and a writeback share this edge
    cyc();
    checks++;
    if (pend_cnt !== 3'd2) begin
      errors++;
      $display("FAIL inc_dec_same: got pend=%0d expected 2", pend_cnt);
    end
    in_valid = 1'b0; in_s = 1'b0;
    cyc(); cyc();
    flag_wb_valid = 1'b0;
    checks++;
    if ({pend_cnt, wb_err} !== 4'b000_0) begin
      errors++;
      $display("FAIL full_drain: got pend=%0d err=%b expected 0 0", pend_cnt, wb_err);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_cond = 4'd14; in_s = 1'b0;
    cyc();
    in_cond = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, out_exec, out_set_flags} !== 4'b0110) begin
        errors++;
        $display("FAIL hold_stable %0d: got rdy=%b ov=%b ex=%b sf=%b expected 0 1 1 0",
                 i, in_ready, out_valid, out_exec, out_set_flags);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got in_ready=%b expected 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_squash();
    set_sr(4'b0100);
    in_valid = 1'b1; in_cond = 4'd12; in_s = 1'b1;
    cyc();
    checks++;
    if ({out_valid, out_exec, out_set_flags, pend_cnt} !== 6'b100_000) begin
      errors++;
      $display("FAIL gt_squash: got ov=%b ex=%b sf=%b pend=%0d expected 1 0 0 0",
               out_valid, out_exec, out_set_flags, pend_cnt);
    end
    in_valid = 1'b0; in_s = 1'b0;
    cyc();
  endtask

  task automatic test_wb_err();
    flag_wb_valid = 1'b1; flag_wb = 4'b1010;
    cyc();
    flag_wb_valid = 1'b0;
    checks++;
    if ({wb_err, sr, pend_cnt} !== 8'b1_1010_000) begin
      errors++;
      $display("FAIL stray_wb: got err=%b sr=%b pend=%0d expected 1 1010 0", wb_err, sr, pend_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; in_cond = 4'd14; in_s = 1'b1;
    cyc();
    in_cond = 4'd0; in_s = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_stall: got in_ready=%b expected 0", in_ready);
    end
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    checks++;
    if ({out_valid, out_exec, out_set_flags, sr, pend_cnt, wb_err} !== 11'd0) begin
      errors++;
      $display("FAIL mid_stall_reset: got ov=%b ex=%b sf=%b sr=%b pend=%0d err=%b expected all zero",
               out_valid, out_exec, out_set_flags, sr, pend_cnt, wb_err);
    end
    rst = 1'b0;
    flag_wb_valid = 1'b1; flag_wb = 4'b0011;
    cyc();
    flag_wb_valid = 1'b0;
    checks++;
    if ({wb_err, sr} !== 5'b1_0011) begin
      errors++;
      $display("FAIL post_reset_stray_wb: got err=%b sr=%b expected 1 0011", wb_err, sr);
    end
  endtask

  initial begin
    test_reset();
    test_cond_basic();
    test_back_to_back();
    test_hazard();
    test_full();
    test_backpressure();
    test_squash();
    test_wb_err();
    test_reset_mid_stall();
    cyc(); cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cond_exec_ctrl
`default_nettype wire
